// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// RX line synchroniser plus falling-edge (start bit) detector.
// Flops reset to the idle level so reset release never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rx_s,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;

    // Metastability chain followed by one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{UART_IDLE_LEVEL}};
            r_rx_d <= UART_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rs232_rx};
            r_rx_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s       = r_sync[SYNC_STAGES-1];
    assign start_edge = r_rx_d & ~rx_s;

endmodule : uart_rx_sync

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start detect, baud request, mid-bit sampling, byte delivery.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_int,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    logic w_rx_s;
    logic w_start_edge;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .rx_s       (w_rx_s),
        .start_edge (w_start_edge)
    );

    uart_state_t          r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt,   w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_rx_valid,  w_rx_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit,    w_par_bit_nxt;
    logic                 r_parity_err, w_parity_err_nxt;
`endif

    // State and output registers; everything visible outside is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_busy       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_busy       <= w_busy_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // Next-state and next-output logic; clk_bps only matters once a frame is active.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_busy_nxt       = r_busy;
        w_rx_valid_nxt   = 1'b0;
        w_frame_err_nxt  = r_frame_err;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = r_parity_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = ST_START;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_START: begin
                if (clk_bps) begin
                    if (w_rx_s) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            ST_DATA: begin
                if (clk_bps) begin
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_bps) begin
                    w_par_bit_nxt = w_rx_s;
                    w_state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (clk_bps) begin
                    w_rx_data_nxt    = r_shift;
                    w_frame_err_nxt  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_parity_err_nxt = ^{r_shift, r_par_bit};
`endif
                    w_rx_valid_nxt   = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bps_start = r_busy;
    assign rx_int    = r_busy;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a scaled-down baud generator model.
module tb_uart_rx_frame;

    localparam int BIT  = 64;
    localparam int HALF = BIT / 2;

    logic       clk;
    logic       rst_n;
    logic       rs232_rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    logic [7:0] rxq[$];
    logic mid_bps;
    logic mid_int;
    int v0;

    uart_rx_frame #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs232_rx   (rs232_rx),
        .clk_bps    (clk_bps),
        .bps_start  (bps_start),
        .rx_data    (rx_data),
        .rx_int     (rx_int),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Baud generator model: first strobe half a bit after bps_start, then every bit.
    initial begin
        int p;
        p = 0;
        clk_bps = 1'b0;
        forever begin
            @(negedge clk);
            if (bps_start) begin
                clk_bps = (p >= HALF) && (((p - HALF) % BIT) == 0);
                p++;
            end else begin
                clk_bps = 1'b0;
                p = 0;
            end
        end
    end

    // Collect every delivered byte.
    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt++;
            rxq.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        wait_clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic use_par,
                              input logic par);
        rs232_rx = 1'b0;
        wait_clks(4);
        mid_bps = bps_start;
        mid_int = rx_int;
        wait_clks(BIT - 4);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        mid_bps  = 1'b0;
        mid_int  = 1'b0;
        wait_clks(3);
        check("reset_bps_start", 32'(bps_start), 32'd0);
        check("reset_rx_int", 32'(rx_int), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_clks(BIT);
        check("idle_no_valid", 32'(vcnt), 32'd0);

        // Good frame 0x55.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("s1_mid_bps_start", 32'(mid_bps), 32'd1);
        check("s1_mid_rx_int", 32'(mid_int), 32'd1);
        check("s1_valid_count", 32'(vcnt), 32'd1);
        check("s1_rx_data", 32'(rx_data), 32'h55);
        check("s1_frame_err", 32'(frame_err), 32'd0);
        check("s1_rx_int_low", 32'(rx_int), 32'd0);
        check("s1_bps_low", 32'(bps_start), 32'd0);
        check("s1_parity_err", 32'(parity_err), 32'd0);

        // False start: short low glitch.
        rs232_rx = 1'b0;
        wait_clks(10);
        rs232_rx = 1'b1;
        wait_clks(6);
        check("s2_rx_int_during", 32'(rx_int), 32'd1);
        wait_clks(BIT);
        check("s2_rx_int_drop", 32'(rx_int), 32'd0);
        check("s2_bps_drop", 32'(bps_start), 32'd0);
        check("s2_no_valid", 32'(vcnt), 32'd1);
        check("s2_data_held", 32'(rx_data), 32'h55);

        // Framing error then a good frame.
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        check("s3_valid_count", 32'(vcnt), 32'd2);
        check("s3_rx_data", 32'(rx_data), 32'hA3);
        check("s3_frame_err", 32'(frame_err), 32'd1);
        rs232_rx = 1'b1;
        wait_clks(BIT);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        check("s3b_rx_data", 32'(rx_data), 32'h0F);
        check("s3b_frame_err", 32'(frame_err), 32'd0);

        // Back-to-back frames with a single stop bit between them.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check("s4_valid_count", 32'(vcnt), 32'd5);
        check("s4_first", 32'(rxq[3]), 32'h00);
        check("s4_second", 32'(rxq[4]), 32'hFF);

        // Async reset after four data bits of 0x3C.
        v0 = vcnt;
        rs232_rx = 1'b0;
        wait_clks(BIT);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_bps", 32'(bps_start), 32'd0);
        check("s5_rst_int", 32'(rx_int), 32'd0);
        check("s5_rst_data", 32'(rx_data), 32'd0);
        check("s5_rst_ferr", 32'(frame_err), 32'd0);
        check("s5_rst_valid", 32'(rx_valid), 32'd0);
        wait_clks(3);
        rs232_rx = 1'b1;
        rst_n = 1'b1;
        wait_clks(BIT);
        check("s5_no_spurious", 32'(vcnt), 32'(v0));
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("s5_valid_count", 32'(vcnt), 32'(v0 + 1));
        check("s5_rx_data", 32'(rx_data), 32'h3C);

        // Break: line held low for more than a frame.
        v0 = vcnt;
        rs232_rx = 1'b0;
        wait_clks(12 * BIT);
        check("brk_valid_count", 32'(vcnt), 32'(v0 + 1));
        check("brk_rx_data", 32'(rx_data), 32'h00);
        check("brk_frame_err", 32'(frame_err), 32'd1);
        check("brk_idle", 32'(rx_int), 32'd0);
        rs232_rx = 1'b1;
        wait_clks(BIT);
        check("brk_no_restart", 32'(vcnt), 32'(v0 + 1));

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check("s6_par_ok_data", 32'(rx_data), 32'h07);
        check("s6_par_ok_err", 32'(parity_err), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("s6_par_bad_data", 32'(rx_data), 32'h07);
        check("s6_par_bad_err", 32'(parity_err), 32'd1);
        check("s6_par_bad_ferr", 32'(frame_err), 32'd0);
`else
        check("parity_tied_low", 32'(parity_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_frame
